serial_pair_adder_ctrl: RTL and testbench

- Sequencer that adds (or subtracts) two WIDTH-bit operands by reusing a single 2-bit adder slice over WIDTH/2 cycles.
- A registered carry is chained between slice passes.
- Sits between a requester (start/done handshake) and the lab's small-adder datapath.
- Trades latency for area, the same way multi-bit results are built from 2-bit stages.

---
 rtl/serial_pair_adder_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_pair_adder_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pair_adder_ctrl.sv
// serial_pair_adder_ctrl
// Adds or subtracts two WIDTH-bit operands by passing them two bits at a
// time through one 2-bit adder slice. A registered carry links consecutive
// passes. The requester sees a start/busy/done handshake, and the result
// registers hold their values until the next accepted start.
module serial_pair_adder_ctrl #(
  parameter int WIDTH = 8,  // even, >= 2
  parameter int CNT_W = 3   // 2**CNT_W >= WIDTH/2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_out_o,
  output logic             overflow_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             carry_out_q;
  logic             overflow_q;

  logic [2:0]       slice_d;     // {carry, z[1:0]} of the current pass
  logic [1:0]       bit0_d;      // low-bit sum; [1] is the carry into the slice's upper bit
  logic             last_slice;
  logic [WIDTH-1:0] sum_d;

  // Shared 2-bit slice and merge of its result into the sum register.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    sum_d      = sum_q;
    slice_d    = {1'b0, a_sh_q[1:0]} + {1'b0, b_sh_q[1:0]} + {2'b00, carry_q};
    bit0_d     = {1'b0, a_sh_q[0]} + {1'b0, b_sh_q[0]} + {1'b0, carry_q};
    last_slice = (cnt_q == CNT_W'(WIDTH / 2 - 1));
    for (int k = 0; k < WIDTH / 2; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        sum_d[2*k +: 2] = slice_d[1:0];
      end
    end
  end

  // Sequencer: IDLE latches operands, RUN does one slice per cycle, DONE
  // closes out the operation and raises done as the machine returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state and datapath registers, including the operand shifters, are all cleared by reset so an aborted operation leaves nothing behind.
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_sh_q  <= a_i;
            b_sh_q  <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i;  // +1 completes the two's-complement negation of b
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_d[2];
          a_sh_q  <= a_sh_q >> 2;
          b_sh_q  <= b_sh_q >> 2;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_slice) begin
            carry_out_q <= slice_d[2];
            overflow_q  <= bit0_d[1] ^ slice_d[2];
            busy_q      <= 1'b0;
            state_q     <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sum_o       = sum_q;
  assign carry_out_o = carry_out_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_serial_pair_adder_ctrl.sv
// Testbench for serial_pair_adder_ctrl: an 8-bit and a 2-bit instance,
// with directed cases and a random sweep compared against an
// arithmetic reference model.
module tb_serial_pair_adder_ctrl;

  logic clk;
  logic rst;

  // 8-bit instance
  logic       start8_i, sub8_i;
  logic [7:0] a8_i, b8_i;
  logic       busy8_o, done8_o, co8_o, ov8_o;
  logic [7:0] sum8_o;

  // 2-bit instance
  logic       start2_i, sub2_i;
  logic [1:0] a2_i, b2_i;
  logic       busy2_o, done2_o, co2_o, ov2_o;
  logic [1:0] sum2_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the most recent 8-bit operation, from the model
  int unsigned exp8_s;
  bit          exp8_co, exp8_ov;

  serial_pair_adder_ctrl #(.WIDTH(8), .CNT_W(3)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start8_i),
    .sub_i       (sub8_i),
    .a_i         (a8_i),
    .b_i         (b8_i),
    .busy_o      (busy8_o),
    .done_o      (done8_o),
    .sum_o       (sum8_o),
    .carry_out_o (co8_o),
    .overflow_o  (ov8_o)
  );

  serial_pair_adder_ctrl #(.WIDTH(2), .CNT_W(1)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start2_i),
    .sub_i       (sub2_i),
    .a_i         (a2_i),
    .b_i         (b2_i),
    .busy_o      (busy2_o),
    .done_o      (done2_o),
    .sum_o       (sum2_o),
    .carry_out_o (co2_o),
    .overflow_o  (ov2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on w-bit unsigned operands, modulo 2**w.
  function automatic void ref_op(input int w, input int unsigned a, input int unsigned b,
                                 input bit sub, output int unsigned s,
                                 output bit co, output bit ov);
    int unsigned m;
    int unsigned full;
    bit sa, sb, sr;
    m    = 32'd1 << w;
    full = sub ? (a + (m - b)) : (a + b);
    s    = full % m;
    co   = sub ? (a >= b) : (full >= m);
    sa   = (a >= m / 2);
    sb   = (b >= m / 2);
    sr   = (s >= m / 2);
    ov   = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
  endfunction

  // One 8-bit operation checked cycle by cycle. Operands are scrambled
  // right after acceptance; optional start pulses in RUN and DONE must be
  // ignored.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                     input bit pulse_run, input bit pulse_done);
    ref_op(8, a, b, sub, exp8_s, exp8_co, exp8_ov);
    @(posedge clk); #1;
    a8_i = a; b8_i = b; sub8_i = sub; start8_i = 1'b1;
    @(posedge clk); #1;  // acceptance edge
    start8_i = 1'b0;
    a8_i = 8'($urandom); b8_i = 8'($urandom); sub8_i = 1'($urandom);
    for (int c = 1; c <= 6; c++) begin
      start8_i = (c == 2 && pulse_run) || (c == 5 && pulse_done);
      @(negedge clk);
      check("busy8", 32'(busy8_o), 32'(c <= 4));
      check("done8", 32'(done8_o), 32'(c == 6));
      if (c == 6) begin
        check("sum8", 32'(sum8_o), exp8_s);
        check("co8", 32'(co8_o), 32'(exp8_co));
        check("ov8", 32'(ov8_o), 32'(exp8_ov));
      end
      if (c < 6) begin
        @(posedge clk); #1;
      end
    end
    start8_i = 1'b0;
  endtask

  // One 2-bit operation: one RUN cycle, one DONE cycle, then done.
  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic sub);
    int unsigned s;
    bit co, ov;
    ref_op(2, a, b, sub, s, co, ov);
    @(posedge clk); #1;
    a2_i = a; b2_i = b; sub2_i = sub; start2_i = 1'b1;
    @(posedge clk); #1;
    start2_i = 1'b0;
    a2_i = 2'($urandom); b2_i = 2'($urandom); sub2_i = 1'($urandom);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("busy2", 32'(busy2_o), 32'(c == 1));
      check("done2", 32'(done2_o), 32'(c == 3));
      if (c == 3) begin
        check("sum2", 32'(sum2_o), s);
        check("co2", 32'(co2_o), 32'(co));
        check("ov2", 32'(ov2_o), 32'(ov));
      end
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int done_cnt;
    int last_idx;
    int pulses;

    rst = 1'b1;
    start8_i = 1'b0; sub8_i = 1'b0; a8_i = '0; b8_i = '0;
    start2_i = 1'b0; sub2_i = 1'b0; a2_i = '0; b2_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy8", 32'(busy8_o), 32'd0);
    check("rst_done8", 32'(done8_o), 32'd0);
    check("rst_sum8", 32'(sum8_o), 32'd0);
    check("rst_co8", 32'(co8_o), 32'd0);
    check("rst_ov8", 32'(ov8_o), 32'd0);
    check("rst_busy2", 32'(busy2_o), 32'd0);
    check("rst_sum2", 32'(sum2_o), 32'd0);
    rst = 1'b0;

    // Basic add, carry ripple, overflow, subtract cases
    op8(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    op8(8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
    op8(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);

    // Start pulses during RUN and DONE are ignored
    op8(8'hA5, 8'h3C, 1'b0, 1'b1, 1'b1);
    op8(8'h5A, 8'hC3, 1'b1, 1'b1, 1'b1);

    // Result holds while operand inputs toggle with start low
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      a8_i = 8'($urandom); b8_i = 8'($urandom); sub8_i = 1'($urandom);
      @(negedge clk);
      check("hold_sum8", 32'(sum8_o), exp8_s);
      check("hold_co8", 32'(co8_o), 32'(exp8_co));
      check("hold_ov8", 32'(ov8_o), 32'(exp8_ov));
      check("hold_busy8", 32'(busy8_o), 32'd0);
      check("hold_done8", 32'(done8_o), 32'd0);
    end

    // Reset asserted in the second RUN cycle aborts the operation
    @(posedge clk); #1;
    a8_i = 8'hFF; b8_i = 8'h01; sub8_i = 1'b0; start8_i = 1'b1;
    @(posedge clk); #1;
    start8_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_busy8", 32'(busy8_o), 32'd0);
    check("abort_done8", 32'(done8_o), 32'd0);
    check("abort_sum8", 32'(sum8_o), 32'd0);
    check("abort_co8", 32'(co8_o), 32'd0);
    check("abort_ov8", 32'(ov8_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done8_o === 1'b1) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_idle_busy", 32'(busy8_o), 32'd0);
    op8(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0);

    // Start held high: done pulses every WIDTH/2+2 = 6 cycles
    ref_op(8, 32'h12, 32'h34, 1'b0, exp8_s, exp8_co, exp8_ov);
    @(posedge clk); #1;
    a8_i = 8'h12; b8_i = 8'h34; sub8_i = 1'b0; start8_i = 1'b1;
    last_idx = -1;
    pulses   = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (done8_o === 1'b1) begin
        pulses++;
        check("held_sum8", 32'(sum8_o), exp8_s);
        if (last_idx >= 0) check("held_spacing", 32'(i - last_idx), 32'd6);
        last_idx = i;
      end
    end
    check("held_pulses", 32'(pulses >= 4), 32'd1);
    start8_i = 1'b0;
    repeat (8) @(negedge clk);
    check("held_end_busy8", 32'(busy8_o), 32'd0);

    // WIDTH=2 directed corners
    op2(2'b11, 2'b01, 1'b0);
    op2(2'b01, 2'b01, 1'b0);
    op2(2'b10, 2'b01, 1'b1);
    op2(2'b00, 2'b01, 1'b1);

    // Random sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    end
    for (int i = 0; i < 1000; i++) begin
      op2(2'($urandom), 2'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
